lcd_frame_scheduler: RTL
========================

Name: lcd_frame_scheduler

Overview:
- Shares the 16x2 character LCD between four message sources (e.g. monitor scene, missed-dose scene, pill schedule, alarm).
- Runs the display power-up command sequence itself.
- Arbitrates refresh requests round-robin and streams one 32-character frame per grant straight onto the LCD pins.
- All pin timing is paced by a 1 ms enable strobe from the existing millisecond divider.

Parameters:
- INIT_WAIT, 20, power-on settle time in ticks before the first command.
- CLEAR_WAIT, 2, extra idle ticks after the clear-display command (0x01).

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- tick  input  1  1 ms enable strobe, one clk cycle high; all state advances only on clk edges with tick=1
- req  input  4  refresh request per source; level or pulse, sampled every clk
- char_data  input  8  ASCII byte of selected source/index; combinational, valid same cycle
- char_sel  output  2  source currently being fetched (= granted source)
- char_idx  output  5  character index 0..31 (0-15 line 1, 16-31 line 2)
- grant  output  2  source owning the current frame
- busy  output  1  high during INIT or while a frame is in progress
- done  output  1  one-clk pulse at frame completion
- LCD_ON  output  1  display power, constant 1
- LCD_RW  output  1  constant 0 (write-only)
- LCD_RS  output  1  0 = command, 1 = data
- LCD_EN  output  1  enable strobe
- LCD_DATA  output  8  byte on LCD bus

Behaviour:
- Reset (async, resetn=0):
  - State = INIT_DLY, busy=1, LCD_ON=1, LCD_RW=0, LCD_EN=0, LCD_RS=0, LCD_DATA=0x00.
  - grant=0, char_sel=0, char_idx=0, done=0, pending=0000.
  - Round-robin pointer last=3, so source 0 wins first.
- Pending latch:
  - pending[i] is set on any clk with req[i]=1, including during INIT and during frames.
  - pending[grant] is cleared on the clk the grant is issued; set wins if req[grant]=1 on that same clk.
- Byte write (2 ticks):
  - Phase A tick: drive LCD_RS and LCD_DATA, set LCD_EN=1.
  - Phase B tick: LCD_EN=0, RS/DATA held.
  - The next byte's phase A is on the following tick.
  - RS/DATA change only on phase A ticks.
- INIT_DLY: count INIT_WAIT ticks with LCD_EN=0, then go to INIT_CMD.
- INIT_CMD:
  - Write commands in order: 0x38, 0x0C, 0x01, 0x06.
  - After 0x01 phase B, wait CLEAR_WAIT ticks (EN=0) before 0x06.
  - After 0x06 phase B, go to IDLE.
  - Total INIT duration = INIT_WAIT + 8 + CLEAR_WAIT ticks.
- IDLE:
  - busy=0.
  - On a clk where pending != 0 (tick not required), pick the first set bit searching last+1, last+2, ... modulo 4.
  - On that clk: set grant=last=winner, clear its pending bit, busy=1, go to ADDR1.
- Frame sequence:
  - ADDR1 writes command 0x80.
  - CHARS1 writes char_idx 0..15 with RS=1.
  - ADDR2 writes command 0xC0.
  - CHARS2 writes char_idx 16..31 with RS=1.
  - Frame = 34 bytes = 68 ticks.
- Character fetch:
  - char_sel=grant throughout the frame.
  - char_idx is updated before the phase A tick of each char.
  - char_data is captured into LCD_DATA on the phase A tick.
  - Sources must hold content stable while that index is selected.
- Frame end:
  - On the phase B tick of char 31: done=1 for exactly that one clk, busy=0, go to IDLE, char_idx=0.
  - A new grant may issue on the next clk.
- Grant stability: grant never changes mid-frame. Requests arriving mid-frame, including from the granted source, are only latched.
- tick=0 clocks: no state, pin or counter change, except pending latching and the IDLE grant decision.
- Reset mid-frame or mid-init: immediate return to reset values and restart of the full INIT sequence.

Test Plan:
- Power-up, INIT_WAIT=20, CLEAR_WAIT=2, tick every 4 clk:
  - Expect LCD_EN first high on tick 21 with DATA=0x38, RS=0.
  - Command order 0x38, 0x0C, 0x01, 0x06.
  - 2 idle ticks after 0x01.
  - busy falls after 30 ticks.
- Single req[2] pulse during INIT:
  - Latched; grant=2 on the first clk in IDLE.
  - Bus sequence 0x80, 32 chars from src 2 (RS=1), 0xC0 between idx 15 and 16.
  - done pulses once after 68 ticks.
- req=1111 held continuously: grants go 0, 1, 2, 3, 0; each frame is 68 ticks; no source starved.
- req[1] re-asserted mid-frame of source 1: the frame completes unchanged, then source 1 is granted again if no other source is pending.
- tick held 0 for 100 clk mid-frame: LCD pins, char_idx and grant are frozen; the frame resumes exactly on the next tick.
- resetn pulsed low during char 10 of a frame: outputs return to reset values immediately, pending=0, INIT restarts from tick 1.

Source files
------------

// File: rtl/lcd_frame_scheduler.sv
// lcd_frame_scheduler: runs the LCD power-up command sequence, then round-robin streams
// one 32-character frame per granted source onto the LCD pins, paced by a 1 ms tick.
module lcd_frame_scheduler #(
  parameter int INIT_WAIT  = 20,
  parameter int CLEAR_WAIT = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic [3:0] req,
  input  logic [7:0] char_data,
  output logic [1:0] char_sel,
  output logic [4:0] char_idx,
  output logic [1:0] grant,
  output logic       busy,
  output logic       done,
  output logic       LCD_ON,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA
);
  typedef enum logic [2:0] {INIT_DLY, INIT_CMD, CLR_WAIT, IDLE, ADDR1, CHARS1, ADDR2, CHARS2} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ph_q, ph_d, en_q, en_d, rs_q, rs_d, done_q, done_d;
  logic [7:0]  data_q, data_d, init_byte;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  grant_q, grant_d, last_q, last_d, win, j;
  logic [3:0]  pend_q, pend_d, clr;
  logic        is_char;
  assign init_byte = cnt_q[1:0] == 2'd0 ? 8'h38 :
                     cnt_q[1:0] == 2'd1 ? 8'h0C :
                     cnt_q[1:0] == 2'd2 ? 8'h01 : 8'h06;
  assign is_char = state_q == CHARS1 || state_q == CHARS2;
  assign pend_d  = (pend_q & ~clr) | req;
  // Scan from the farthest candidate back so the nearest set bit after last_q wins.
  always_comb begin
    win = last_q;
    j   = last_q;
    for (int k = 4; k >= 1; k--) begin
      j = last_q + 2'(k);
      if (pend_q[j]) win = j;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    last_d  = last_q;
    done_d  = 1'b0;
    clr     = 4'b0;
    case (state_q)
      INIT_DLY: if (tick) begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(INIT_WAIT - 1)) begin
          state_d = INIT_CMD;
          cnt_d   = '0;
        end
      end
      CLR_WAIT: if (tick) begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(CLEAR_WAIT - 1)) begin
          state_d = INIT_CMD;
          cnt_d   = 16'd3;
        end
      end
      INIT_CMD: if (tick) begin
        ph_d = ~ph_q;
        en_d = ~ph_q;
        if (!ph_q) begin
          rs_d   = 1'b0;
          data_d = init_byte;
        end else if (cnt_q == 16'd3) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 16'd2 && CLEAR_WAIT > 0) begin
          state_d = CLR_WAIT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      IDLE: if (|pend_q) begin
        state_d  = ADDR1;
        grant_d  = win;
        last_d   = win;
        clr[win] = 1'b1;
      end
      default: if (tick) begin
        ph_d = ~ph_q;
        en_d = ~ph_q;
        if (!ph_q) begin
          rs_d   = is_char;
          data_d = is_char ? char_data : (state_q == ADDR1 ? 8'h80 : 8'hC0);
        end else begin
          idx_d   = is_char ? idx_q + 5'd1 : idx_q;
          done_d  = state_q == CHARS2 && idx_q == 5'd31;
          state_d = state_q == ADDR1  ? CHARS1 :
                    state_q == ADDR2  ? CHARS2 :
                    state_q == CHARS1 ? (idx_q == 5'd15 ? ADDR2 : CHARS1) :
                                        (idx_q == 5'd31 ? IDLE  : CHARS2);
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= INIT_DLY;
      cnt_q   <= '0;
      ph_q    <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      last_q  <= 2'd3;
      done_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end
  assign char_sel = grant_q;
  assign char_idx = idx_q;
  assign grant    = grant_q;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign LCD_ON   = 1'b1;
  assign LCD_RW   = 1'b0;
  assign LCD_RS   = rs_q;
  assign LCD_EN   = en_q;
  assign LCD_DATA = data_q;
endmodule
